// File: rtl/writeback_arbiter_pkg.sv
// Package for the writeback arbiter: field widths, grant selector type and
// a helper that turns a destination register into a busy-mask bit.
package writeback_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_FIFO
    } grant_t;

    // One-hot of a destination register; x0 never marks anything busy.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (rd != '0) begin
            mask[rd] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/defines.v
// Shared register-file write-port encodings used across the pipeline.
`ifndef WB_DEFINES_V
`define WB_DEFINES_V

`define REG_WRITE_ENABLE 1'b1
`define ZERO_WORD        32'h0000_0000

`endif

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: in-order buffer of long-latency writeback results (rd, data).
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_push, i_push_rd/_data   enqueue (ignored when full)
//   i_pop                     dequeue head (ignored when empty)
//   o_full, o_empty, o_count  occupancy from registered state
//   o_head_rd, o_head_data    oldest entry
//   o_entry_valid, o_entry_rd per-slot occupancy and destination, for the busy mask
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_push,
    input  logic [REG_ADDR_W-1:0]                i_push_rd,
    input  logic [DATA_W-1:0]                    i_push_data,
    input  logic                                 i_pop,
    output logic                                 o_full,
    output logic                                 o_empty,
    output logic [CNT_W-1:0]                     o_count,
    output logic [REG_ADDR_W-1:0]                o_head_rd,
    output logic [DATA_W-1:0]                    o_head_data,
    output logic [DEPTH-1:0]                     o_entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_entry_rd
);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];
    logic [DEPTH-1:0]      slot_valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push_ok;
    logic                  pop_ok;

    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            if (push_ok) begin
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            rd_mem[wr_ptr]   <= i_push_rd;
            data_mem[wr_ptr] <= i_push_data;
        end
    end

    assign o_count       = count;
    assign o_head_rd     = rd_mem[rd_ptr];
    assign o_head_data   = data_mem[rd_ptr];
    assign o_entry_valid = slot_valid;

    always_comb begin
        o_entry_rd = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_entry_rd[i] = rd_mem[i];
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the single register-file write port between the
// single-cycle ALU path and buffered long-latency (LSU/muldiv) results.
// ALU has priority unless the FIFO head has waited STARVE_LIMIT cycles.
// Ports:
//   i_clock, i_reset                      clock, synchronous active-high reset
//   i_alu_valid/_rd/_data, o_alu_stall    ALU result; stall means hold request
//   i_lsu_valid/_rd/_data, o_lsu_ready    LSU result handshake into the FIFO
//   o_readwrite/o_writereg/o_writedata    registered register-file write port
//   o_busy_mask                           registers with a buffered write pending
`include "defines.v"

module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [DATA_W-1:0]     i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [DATA_W-1:0]     i_lsu_data,
    output logic                  o_alu_stall,
    output logic                  o_readwrite,
    output logic [REG_ADDR_W-1:0] o_writereg,
    output logic [DATA_W-1:0]     o_writedata,
    output logic [NUM_REGS-1:0]   o_busy_mask
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic                                  fifo_full;
    logic                                  fifo_empty;
    logic [CNT_W-1:0]                      fifo_count;
    logic [REG_ADDR_W-1:0]                 head_rd;
    logic [DATA_W-1:0]                     head_data;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
    logic                                  push;
    logic                                  pop;
    logic                                  starved;
    logic [STV_W-1:0]                      starve_cnt;
    grant_t                                grant;
    logic [NUM_REGS-1:0]                   pending_mask;

    // Ready depends only on registered occupancy: a full FIFO never takes a
    // push even when its head is popped in the same cycle.
    assign o_lsu_ready = !i_reset && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push        = i_lsu_valid && o_lsu_ready && !fifo_full;
    assign starved     = !fifo_empty && (starve_cnt == STV_W'(STARVE_LIMIT));

    always_comb begin
        grant = GRANT_NONE;
        if (!i_reset) begin
            if (starved) begin
                grant = GRANT_FIFO;
            end else if (i_alu_valid) begin
                grant = GRANT_ALU;
            end else if (!fifo_empty) begin
                grant = GRANT_FIFO;
            end
        end
    end

    assign pop         = (grant == GRANT_FIFO);
    assign o_alu_stall = !i_reset && i_alu_valid && starved;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_push        (push),
        .i_push_rd     (i_lsu_rd),
        .i_push_data   (i_lsu_data),
        .i_pop         (pop),
        .o_full        (fifo_full),
        .o_empty       (fifo_empty),
        .o_count       (fifo_count),
        .o_head_rd     (head_rd),
        .o_head_data   (head_data),
        .o_entry_valid (entry_valid),
        .o_entry_rd    (entry_rd)
    );

    // Counts cycles the current head has been passed over; restarts per head.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Writes to x0 still consume their source but never enable the port.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_readwrite <= ~(`REG_WRITE_ENABLE);
            o_writereg  <= '0;
            o_writedata <= `ZERO_WORD;
        end else begin
            case (grant)
                GRANT_ALU: begin
                    o_readwrite <= (i_alu_rd != '0) ? `REG_WRITE_ENABLE : ~(`REG_WRITE_ENABLE);
                    o_writereg  <= i_alu_rd;
                    o_writedata <= i_alu_data;
                end
                GRANT_FIFO: begin
                    o_readwrite <= (head_rd != '0) ? `REG_WRITE_ENABLE : ~(`REG_WRITE_ENABLE);
                    o_writereg  <= head_rd;
                    o_writedata <= head_data;
                end
                default: begin
                    o_readwrite <= ~(`REG_WRITE_ENABLE);
                end
            endcase
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask = pending_mask | rd_onehot(entry_rd[i]);
            end
        end
    end

    assign o_busy_mask = i_reset ? '0 : pending_mask;

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered long-latency results (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, cycles a buffered result may wait before forced grant.
REQ-003 i_clock  in  1  sole clock, all state updates on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_alu_valid  in  1  single-cycle-path result present this cycle.
REQ-006 i_alu_rd  in  5  ALU destination register.
REQ-007 i_alu_data  in  32  ALU result.
REQ-008 i_lsu_valid  in  1  long-latency (load/muldiv) result offered.
REQ-009 o_lsu_ready  out  1  arbiter accepts LSU result this cycle.
REQ-010 i_lsu_rd  in  5  LSU destination register.
REQ-011 i_lsu_data  in  32  LSU result.
REQ-012 o_alu_stall  out  1  ALU source must hold its request; not granted this cycle.
REQ-013 o_readwrite  out  1  register-file write enable, active value `REG_WRITE_ENABLE.
REQ-014 o_writereg  out  5  register-file write address.
REQ-015 o_writedata  out  32  register-file write data.
REQ-016 o_busy_mask  out  32  bit n set while a buffered write to xn is pending.

Function
REQ-017 SHALL buffer LSU results in an in-order FIFO of FIFO_DEPTH entries (rd, data); push when i_lsu_valid && o_lsu_ready.
REQ-018 o_lsu_ready SHALL equal (count < FIFO_DEPTH), from registered count only; no push-through when full, even if a pop occurs same cycle.
REQ-019 Grant per cycle: if starve counter == STARVE_LIMIT and FIFO non-empty -> FIFO head; else if i_alu_valid -> ALU; else if FIFO non-empty -> FIFO head; else none.
REQ-020 o_alu_stall SHALL be 1 exactly when i_alu_valid and FIFO head granted by starvation rule; otherwise 0.
REQ-021 Granted write SHALL be registered into o_readwrite/o_writereg/o_writedata; visible cycle N+1 for grant at cycle N; o_readwrite deasserts the cycle after no grant.
REQ-022 LSU latency: push at N -> earliest write visible at N+2.
REQ-023 Grant of rd==0 SHALL consume the source (pop/accept) but drive o_readwrite=0.
REQ-024 Starve counter SHALL increment each cycle FIFO non-empty and head not granted, saturate at STARVE_LIMIT, clear on any FIFO pop or when FIFO empty.
REQ-025 FIFO order SHALL never be changed; ALU and LSU writes are not merged or cancelled.
REQ-026 o_busy_mask SHALL be combinational OR of one-hot(rd) over valid FIFO entries, rd==0 excluded; output register not included (register file forwards write data).
REQ-027 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-028 Hazard contract: upstream SHALL not issue ALU write to a register set in o_busy_mask; arbiter does not check it.

Reset
REQ-029 On i_reset=1 at a clock edge: FIFO emptied, pointers/count/starve counter 0, o_readwrite=0, o_writereg=0, o_writedata=`ZERO_WORD.
REQ-030 During reset o_lsu_ready=0, o_alu_stall=0, o_busy_mask=0; inputs ignored; in-flight results discarded.
REQ-031 First push accepted on first edge after i_reset falls.

Structure
REQ-032 `REG_WRITE_ENABLE, `ZERO_WORD SHALL come from shared defines.v; no local redefinition.
REQ-033 FIFO SHALL be a sub-module wb_fifo (push/pop/full/empty/count, head rd/data, per-entry valid+rd exported for mask).
REQ-034 Grant logic, starve counter, output register SHALL live in writeback_arbiter top.

Verification
REQ-035 ALU only: alu_valid, rd=5, data=0x1234 at N -> readwrite=1, writereg=5, writedata=0x1234 at N+1.
REQ-036 LSU idle path: lsu push rd=7, data=0xDEAD at N, ALU idle -> busy_mask[7]=1 at N+1, write at N+2, mask clear at N+2.
REQ-037 Full: 3 LSU offers back-to-back with ALU valid every cycle -> ready=0 on third, ALU writes continue, no loss.
REQ-038 Starvation: FIFO holds 1 entry, ALU valid continuously -> after 4 waiting cycles alu_stall=1 one cycle, LSU write appears, ALU resumes next cycle.
REQ-039 x0: ALU rd=0 data=0xFFFF_FFFF -> readwrite=0; LSU rd=0 push -> popped, no write, busy_mask stays 0.
REQ-040 Reset mid-operation: FIFO 2 entries, assert i_reset one cycle -> all outputs reset values, queued writes never appear.
